// File: rtl/root_square_pkg.sv
// root_square_pkg: shared state encoding and sizing helpers for the squarer
package root_square_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/root_square_step.sv
// root_square_step: one combinational shift-add partial-product step
module root_square_step
  import root_square_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] a_next,
  output logic [WIDTH-1:0]   m_next
);
  always_comb begin
    acc_next = m[0] ? acc + a : acc;
    a_next = a << 1;
    m_next = m >> 1;
  end
endmodule

// File: rtl/root_square.sv
// root_square: sequential shift-add squarer, one partial product per clock
module root_square
  import root_square_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic [WIDTH-1:0]   Root_i,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [2*WIDTH-1:0] Square_o,
  output logic               Busy
);
  localparam int CW = cnt_w(WIDTH);
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] acc, a, acc_n, a_n;
  logic [WIDTH-1:0] m, m_n;
  logic [CW-1:0] cnt;
  logic last;
  root_square_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc), .a(a), .m(m),
    .acc_next(acc_n), .a_next(a_n), .m_next(m_n)
  );
  always_comb begin
    In_ready = state_q == IDLE;
    Out_valid = state_q == DONE;
    Busy = !In_ready;
    last = state_q == CALC && cnt == CW'(WIDTH - 1);
    state_d = (In_ready && In_valid) ? CALC :
              last ? DONE :
              (Out_valid && Out_ready) ? IDLE : state_q;
  end
  // Square_o is a separate register so it survives acc being cleared on the next accept
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      acc <= '0;
      a <= '0;
      m <= '0;
      cnt <= '0;
      Square_o <= '0;
    end else begin
      state_q <= state_d;
      if (In_ready && In_valid) begin
        a <= {{WIDTH{1'b0}}, Root_i};
        m <= Root_i;
        acc <= '0;
        cnt <= '0;
      end else if (state_q == CALC) begin
        acc <= acc_n;
        a <= a_n;
        m <= m_n;
        cnt <= cnt + 1'b1;
        if (last) Square_o <= acc_n;
      end
    end
  end
endmodule

// File: tb/tb_root_square.sv
// tb_root_square: directed scoreboard bench for the shift-add squarer
module tb_root_square;
  localparam int W = 8;
  logic Clk = 1'b0;
  logic Rst, In_valid, In_ready, Out_valid, Out_ready, Busy;
  logic [W-1:0] Root_i;
  logic [2*W-1:0] Square_o;
  int vectors = 0;
  int miscompares = 0;
  logic [2*W-1:0] sb[$];
  int lat;
  int seen;
  always #5 Clk = ~Clk;
  root_square #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_ready(In_ready),
    .Root_i(Root_i), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Square_o(Square_o), .Busy(Busy)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic accept(input logic [W-1:0] v);
    check("in_ready_before_accept", 32'(In_ready), 1);
    Root_i = v;
    In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    sb.push_back((2*W)'(v) * (2*W)'(v));
  endtask
  // edges from the accept edge until Out_valid is seen high
  task automatic wait_done(output int n);
    n = 0;
    while (!Out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask
  task automatic take(input string tag);
    logic [2*W-1:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    check({tag, "_valid"}, 32'(Out_valid), 1);
    check({tag, "_square"}, 32'(Square_o), 32'(exp));
  endtask
  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction
  initial begin
    int fir_vals[2] = '{144, 150};
    logic [W-1:0] edge_ops[3] = '{8'd0, 8'd1, 8'd255};
    Rst = 1'b1; In_valid = 1'b0; Out_ready = 1'b0; Root_i = '0;
    tick(); tick();
    check("rst_in_ready", 32'(In_ready), 1);
    check("rst_out_valid", 32'(Out_valid), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_square", 32'(Square_o), 0);
    Rst = 1'b0;
    // basic operand, single-cycle result pulse; WIDTH edges = WIDTH+1 cycles incl. accept
    Out_ready = 1'b1;
    accept(8'd15);
    check("busy_in_calc", 32'(Busy), 1);
    check("in_ready_in_calc", 32'(In_ready), 0);
    wait_done(lat);
    check("lat_15", 32'(lat), W);
    take("op15");
    tick();
    check("pulse_15", 32'(Out_valid), 0);
    check("in_ready_after_15", 32'(In_ready), 1);
    check("hold_15", 32'(Square_o), 225);
    foreach (edge_ops[i]) begin
      accept(edge_ops[i]);
      wait_done(lat);
      check("lat_edge", 32'(lat), W);
      take("edge");
      tick();
    end
    // back-pressure
    Out_ready = 1'b0;
    accept(8'd12);
    wait_done(lat);
    check("lat_12", 32'(lat), W);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(Out_valid), 1);
      check("bp_square", 32'(Square_o), 144);
      tick();
    end
    Out_ready = 1'b1;
    take("op12");
    tick();
    check("bp_released", 32'(Out_valid), 0);
    check("bp_in_ready", 32'(In_ready), 1);
    check("bp_hold", 32'(Square_o), 144);
    // In_valid held high; second operand waits for first transfer
    accept(8'd3);
    In_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      Root_i = 8'($urandom);
      tick();
    end
    check("held_not_accepted", 32'(In_ready), 0);
    Root_i = 8'd200;
    tick();
    take("op3");
    tick();
    check("in_ready_after_3", 32'(In_ready), 1);
    sb.push_back(16'd40000);
    tick();
    In_valid = 1'b0;
    check("accepted_200", 32'(Busy), 1);
    for (int k = 0; k < 3; k++) begin
      Root_i = 8'($urandom);
      tick();
    end
    wait_done(lat);
    check("lat_200", 32'(lat), W - 3);
    take("op200");
    tick();
    // reset during the 4th CALC cycle discards the operation
    accept(8'd77);
    tick(); tick(); tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    sb.delete();
    check("midrst_valid", 32'(Out_valid), 0);
    check("midrst_square", 32'(Square_o), 0);
    check("midrst_in_ready", 32'(In_ready), 1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (Out_valid) seen++;
      tick();
    end
    check("midrst_no_output", 32'(seen), 0);
    accept(8'd5);
    wait_done(lat);
    take("op5");
    tick();
    // round-trip against FIR magnitude through an integer floor root
    foreach (fir_vals[i]) begin
      int c;
      c = isqrt(fir_vals[i]);
      accept(W'(c));
      wait_done(lat);
      take("roundtrip");
      check("floor_low", 32'(Square_o <= 16'(fir_vals[i])), 1);
      check("floor_high", 32'(fir_vals[i] < (c + 1) * (c + 1)), 1);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/root_square.md
# root_square

Sequential shift-add squarer that computes `Square_o = Root_i * Root_i`. It is the inverse companion of the FIR/ROOT datapath's square-root stage. It sits after ROOT to reconstruct the squared magnitude, and it is the self-check path that feeds ROOT results back against FIR output. One operand is processed at a time under a valid/ready handshake, with one partial-product step per clock.

## Interface
- `WIDTH`, default 8: operand width; the result is `2*WIDTH` bits.
- `Clk`  in  1  system clock; all logic is rising-edge.
- `Rst`  in  1  synchronous, active-high reset.
- `In_valid`  in  1  `Root_i` holds a valid operand.
- `In_ready`  out  1  block can accept an operand (high only in IDLE).
- `Root_i`  in  WIDTH  unsigned operand.
- `Out_valid`  out  1  `Square_o` holds a completed result.
- `Out_ready`  in  1  consumer accepts the result.
- `Square_o`  out  2*WIDTH  unsigned square.
- `Busy`  out  1  high in CALC or DONE.

## Operation
- FSM states are IDLE, CALC and DONE. Reset state is IDLE.
- IDLE:
  - `In_ready`=1.
  - On `In_valid && In_ready`: load multiplicand `A` = `Root_i` zero-extended to 2*WIDTH; load multiplier `M` = `Root_i`; clear `acc` and the step counter `cnt`; go to CALC.
- CALC, one step per cycle:
  - If `M[0]`, then `acc <= acc + A`.
  - `A <= A << 1`, `M <= M >> 1`, `cnt <= cnt + 1`.
  - When `cnt == WIDTH-1`, go to DONE. Exactly WIDTH steps are performed; there is no early exit on `M==0`.
- DONE:
  - `Out_valid`=1 and `Square_o`=`acc`.
  - On `Out_ready`, go to IDLE.
- Arithmetic:
  - Unsigned throughout; `acc` is 2*WIDTH bits.
  - The maximum result is (2^WIDTH−1)^2, which fits in 2*WIDTH bits, so no overflow is possible.
- Operand capture: `Root_i` is sampled only at the accept cycle. Changes to it afterwards have no effect.
- `In_valid` outside IDLE is ignored, with no side effects.
- `Square_o` holds its value while `Out_valid`=1 and keeps the last result after the transfer, until the next DONE.
- Reset values:
  - State = IDLE.
  - `In_ready`=1 (combinational from state), `Out_valid`=0, `Busy`=0.
  - `Square_o`=0; `acc`, `A`, `M`, `cnt` = 0.
- Reset mid-operation (in CALC or DONE): the operation is discarded with no output. `Out_valid` is low on the cycle after reset.

## Timing
- Operand accepted at rising edge t:
  - CALC occupies edges t+1 … t+WIDTH.
  - `Out_valid` rises after edge t+WIDTH and is visible in cycle t+WIDTH+1.
  - Latency is therefore WIDTH+1 cycles, 9 for the default.
- The result transfers at the first edge where `Out_valid && Out_ready`.
- `In_ready` returns high the cycle after the transfer.
- Minimum accept-to-accept spacing is WIDTH+2 cycles. There is no overlap of DONE and a new accept.
- `Out_ready` held high: `Out_valid` is a single-cycle pulse.
- `Out_ready` low: `Out_valid` stays high and `Square_o` stays stable indefinitely.
- `Rst` has priority over every handshake in the same cycle.

## Structure
- Shared package `root_square_pkg`:
  - State enum (IDLE, CALC, DONE).
  - Default `WIDTH`=8.
  - Counter width `$clog2(WIDTH)`.
- Sub-module `root_square_step`: the combinational single shift-add step (`acc`, `A`, `M` in; next values out). It is instantiated once, and the FSM and registers live in the top.

## Test plan
- `Root_i`=15 with `In_valid` pulsed 1 cycle and `Out_ready`=1 → `Out_valid` for exactly 1 cycle, 9 cycles after accept, with `Square_o`=225.
- Edge operands 0, 1 and 255 → `Square_o`=0, 1 and 65025 respectively. Same latency for each, including 0.
- Back-pressure: `Root_i`=12 with `Out_ready`=0 for 5 cycles after `Out_valid` → `Out_valid` and `Square_o`=144 stable all 5 cycles; transfer on the cycle `Out_ready` rises; `In_ready` high next cycle.
- `In_valid` held high with operands 3 then 200 → the second operand is accepted only after the first transfer (spacing 10 cycles); results 9 then 40000; `Root_i` toggling during CALC does not alter the results.
- `Rst` pulsed 1 cycle at the 4th CALC cycle of operand 77 → no `Out_valid`, `Square_o`=0, `In_ready`=1 the next cycle; a following operand 5 gives 25.
- Round-trip: FIR output 144 → ROOT gives 12 → `root_square` returns 144. Integer-root floor is checked by requiring `Square_o` ≤ FIR output < (`C`+1)^2.
